// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared block constants, pixel type and write-side state encoding
package jpeg_pkg;
  localparam int BLOCK_SIZE = 8;
  typedef logic signed [7:0] pix_t;
  typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DROP} wr_st_t;
  function automatic int beats(input int n);
    return BLOCK_SIZE * BLOCK_SIZE / n;
  endfunction
endpackage

// File: rtl/blk_bank_ram.sv
// blk_bank_ram: simple dual-port RAM, one write port and one registered read port
module blk_bank_ram #(
  parameter int W = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/blk_pingpong_buf.sv
// blk_pingpong_buf: two-bank 8x8 block buffer with framing checks and valid/ready replay
module blk_pingpong_buf
  import jpeg_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     blk_valid,
  input  logic signed [N-1:0][7:0] blk_data_y,
  input  logic signed [N-1:0][7:0] blk_data_cr,
  input  logic signed [N-1:0][7:0] blk_data_cb,
  input  logic                     blk_sob,
  input  logic                     blk_eob,
  input  logic                     blk_sof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [N-1:0][7:0] out_data_y,
  output logic signed [N-1:0][7:0] out_data_cr,
  output logic signed [N-1:0][7:0] out_data_cb,
  output logic                     out_sob,
  output logic                     out_eob,
  output logic                     out_sof,
  output logic                     ovf_err,
  output logic                     proto_err
);
  localparam int BEATS = beats(N);
  localparam int IW = $clog2(BEATS);
  typedef pix_t [N-1:0] pixv_t;
  typedef struct packed { pixv_t cb; pixv_t cr; pixv_t y; } ycc_beat_t;
  typedef struct packed { logic sof; logic eob; logic sob; ycc_beat_t d; } obeat_t;
  wr_st_t wst_q, wst_d;
  logic [IW-1:0] widx_q, widx_d, fidx_q, fidx_d;
  logic wb_q, wb_d, rb_q, rb_d, fb_q, fb_d;
  logic [1:0] full_q, full_d, sof_q, sof_d, occ_q, occ_d;
  logic ovf_q, ovf_d, proto_q, proto_d, p1_q;
  logic [2:0] p1f_q, lvl;
  obeat_t head_q, head_d, skid_q, skid_d, pbeat;
  ycc_beat_t wdata, rdata;
  logic we, full_set, pop, issue, last_w;
  assign wdata = '{cb: blk_data_cb, cr: blk_data_cr, y: blk_data_y};
  assign last_w = widx_q == IW'(BEATS - 1);
  always_comb begin
    wst_d = wst_q;
    widx_d = widx_q;
    wb_d = wb_q;
    sof_d = sof_q;
    we = 1'b0;
    full_set = 1'b0;
    ovf_d = 1'b0;
    proto_d = 1'b0;
    if (blk_valid) begin
      case (wst_q)
        WR_IDLE: begin
          if (!blk_sob) proto_d = 1'b1;
          else if (full_q[wb_q]) begin
            ovf_d = 1'b1;
            wst_d = WR_DROP;
          end else begin
            we = 1'b1;
            sof_d[wb_q] = blk_sof;
            widx_d = IW'(1);
            wst_d = WR_FILL;
          end
        end
        WR_FILL: begin
          if (blk_sob || (blk_eob != last_w)) begin
            proto_d = 1'b1;
            wst_d = WR_IDLE;
          end else begin
            we = 1'b1;
            widx_d = widx_q + IW'(1);
            full_set = blk_eob;
            wb_d = wb_q ^ blk_eob;
            wst_d = blk_eob ? WR_IDLE : WR_FILL;
          end
        end
        default: begin
          proto_d = blk_sob;
          wst_d = (!blk_sob && blk_eob) ? WR_IDLE : WR_DROP;
        end
      endcase
    end
  end
  // Reads run ahead of the output into a two-entry head/skid pair; issue only while a slot is guaranteed.
  assign pbeat = {p1f_q, rdata};
  always_comb begin
    pop = out_valid && out_ready;
    lvl = 3'(occ_q) + 3'(p1_q) - 3'(pop);
    issue = full_q[fb_q] && lvl <= 3'd1;
    fidx_d = issue ? fidx_q + IW'(1) : fidx_q;
    fb_d = fb_q ^ (issue && fidx_q == IW'(BEATS - 1));
    rb_d = rb_q ^ (pop && head_q.eob);
    occ_d = 2'(lvl);
    head_d = (pop && occ_q == 2'd2) ? skid_q : ((occ_q == 2'd0 || pop) && p1_q) ? pbeat : head_q;
    skid_d = (p1_q && occ_d == 2'd2) ? pbeat : skid_q;
    full_d = full_q;
    if (full_set) full_d[wb_q] = 1'b1;
    if (pop && head_q.eob) full_d[rb_q] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wst_q <= WR_IDLE;
      widx_q <= '0;
      fidx_q <= '0;
      wb_q <= 1'b0;
      rb_q <= 1'b0;
      fb_q <= 1'b0;
      full_q <= '0;
      sof_q <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
      proto_q <= 1'b0;
      p1_q <= 1'b0;
      p1f_q <= '0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      wst_q <= wst_d;
      widx_q <= widx_d;
      fidx_q <= fidx_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      fb_q <= fb_d;
      full_q <= full_d;
      sof_q <= sof_d;
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      proto_q <= proto_d;
      p1_q <= issue;
      p1f_q <= {fidx_q == '0 && sof_q[fb_q], fidx_q == IW'(BEATS - 1), fidx_q == '0};
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
  blk_bank_ram #(.W($bits(ycc_beat_t)), .AW(IW + 1)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i ({wb_q, wst_q == WR_IDLE ? IW'(0) : widx_q}),
    .wdata_i (wdata),
    .re_i    (issue),
    .raddr_i ({fb_q, fidx_q}),
    .rdata_o (rdata)
  );
  assign out_valid = occ_q != 2'd0;
  assign out_data_y = head_q.d.y;
  assign out_data_cr = head_q.d.cr;
  assign out_data_cb = head_q.d.cb;
  assign out_sob = head_q.sob;
  assign out_eob = head_q.eob;
  assign out_sof = head_q.sof;
  assign ovf_err = ovf_q;
  assign proto_err = proto_q;
endmodule

// File: tb/tb_blk_pingpong_buf.sv
// tb_blk_pingpong_buf: random block traffic checked against a queue-based buffer model
`timescale 1ns/1ps
module tb_blk_pingpong_buf;
  localparam int N = 2;
  localparam int BEATS = 64 / N;
  localparam int DW = N * 8;
  typedef struct packed { logic [DW-1:0] y, cr, cb; logic sob, eob, sof; } beat_t;
  typedef enum {M_IDLE, M_FILL, M_DROP} mst_t;
  logic clk = 0, rst_n = 0, blk_valid = 0, blk_sob = 0, blk_eob = 0, blk_sof = 0, out_ready = 0;
  logic signed [N-1:0][7:0] blk_data_y = '0, blk_data_cr = '0, blk_data_cb = '0;
  logic signed [N-1:0][7:0] out_data_y, out_data_cr, out_data_cb;
  logic out_valid, out_sob, out_eob, out_sof, ovf_err, proto_err;
  int checks = 0, errors = 0, rdy_mode = 0;
  logic ending = 0;
  beat_t exp_q[$];
  int stored = 0;

  always #5 clk = ~clk;

  blk_pingpong_buf #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid),
    .blk_data_y(blk_data_y), .blk_data_cr(blk_data_cr), .blk_data_cb(blk_data_cb),
    .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_y(out_data_y), .out_data_cr(out_data_cr), .out_data_cb(out_data_cb),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof),
    .ovf_err(ovf_err), .proto_err(proto_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Reference model: inputs seen here are the ones the next rising edge samples.
  mst_t mst = M_IDLE;
  beat_t cur[$];
  logic cur_sof = 0, e_ovf = 0, e_proto = 0;
  int ohs = 0, cyc = 0, lat_k = -10;
  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (!rst_n) begin
      mst = M_IDLE;
      cur.delete();
      exp_q.delete();
      stored = 0;
      ohs = 0;
      e_ovf = 0;
      e_proto = 0;
      lat_k = -10;
    end else begin
      chk("ovf_err", 64'(ovf_err), 64'(e_ovf));
      chk("proto_err", 64'(proto_err), 64'(e_proto));
      if (cyc == lat_k + 2) chk("latency_early", 64'(out_valid), 64'(0));
      if (cyc == lat_k + 3) chk("latency_rise", 64'(out_valid), 64'(1));
      e_ovf = 0;
      e_proto = 0;
      if (blk_valid) begin
        b = '{y: blk_data_y, cr: blk_data_cr, cb: blk_data_cb, sob: 1'b0, eob: 1'b0, sof: 1'b0};
        case (mst)
          M_IDLE: begin
            if (!blk_sob) e_proto = 1;
            else if (stored == 2) begin
              e_ovf = 1;
              mst = M_DROP;
            end else begin
              cur.delete();
              cur.push_back(b);
              cur_sof = blk_sof;
              mst = M_FILL;
            end
          end
          M_FILL: begin
            if (blk_sob) begin
              e_proto = 1;
              mst = M_IDLE;
            end else begin
              cur.push_back(b);
              if (blk_eob && cur.size() == BEATS) begin
                if (stored == 0 && !out_valid) lat_k = cyc;
                foreach (cur[i]) begin
                  b = cur[i];
                  b.sob = i == 0;
                  b.eob = i == BEATS - 1;
                  b.sof = i == 0 && cur_sof;
                  exp_q.push_back(b);
                end
                stored++;
                mst = M_IDLE;
              end else if (blk_eob || cur.size() == BEATS) begin
                e_proto = 1;
                mst = M_IDLE;
              end
            end
          end
          default: begin
            if (blk_sob) e_proto = 1;
            else if (blk_eob) mst = M_IDLE;
          end
        endcase
      end
      if (out_valid && out_ready) begin
        ohs++;
        if (ohs % BEATS == 0) stored--;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  int idle_cyc = 0;
  logic stall = 0;
  beat_t held;
  always @(negedge clk) begin
    beat_t a, e;
    a = '{y: out_data_y, cr: out_data_cr, cb: out_data_cb, sob: out_sob, eob: out_eob, sof: out_sof};
    if (!rst_n) begin
      chk("reset_outputs", 64'({a, out_valid, ovf_err, proto_err}), 64'(0));
      stall = 0;
      idle_cyc = 0;
    end else begin
      if (stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_hold", 64'(a), 64'(held));
      end
      stall = out_valid && !out_ready;
      held = a;
      if (out_valid && out_ready) begin
        idle_cyc = 0;
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(exp_q.size()), 64'(1));
        else begin
          e = exp_q.pop_front();
          chk("out_beat", 64'(a), 64'(e));
        end
      end else if (exp_q.size() != 0) begin
        idle_cyc++;
        if (idle_cyc == 3000) chk("drain_stuck", 64'(exp_q.size()), 64'(0));
      end
      if (ending) chk("leftover_beats", 64'(exp_q.size()), 64'(0));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      blk_valid = 0;
      blk_sob = 0;
      blk_eob = 0;
      blk_sof = 0;
    end
  endtask

  task automatic beat(input logic sob, input logic eob, input logic sof, input logic [DW-1:0] y);
    @(posedge clk);
    #1;
    blk_valid = 1;
    blk_sob = sob;
    blk_eob = eob;
    blk_sof = sof;
    blk_data_y = y;
    blk_data_cr = DW'($urandom);
    blk_data_cb = DW'($urandom);
  endtask

  task automatic send_block(input logic sof, input int eob_at, input int gap, input int rst_at, input logic seq);
    for (int i = 0; i <= eob_at; i++) begin
      if (i == rst_at) begin
        @(posedge clk);
        #1;
        blk_valid = 0;
        rst_n = 0;
        idle(3);
        rst_n = 1;
        return;
      end
      if (gap > 0 && $urandom_range(0, 99) < gap) idle(1);
      beat(i == 0, i == eob_at, sof && i == 0, seq ? DW'(i) : DW'($urandom));
    end
    idle(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && (stored != 0 || out_valid); i++) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    idle(2);
    send_block(0, BEATS - 1, 0, -1, 1);
    drain();
    rdy_mode = 1;
    repeat (8) send_block(1'($urandom_range(0, 1)), BEATS - 1, 20, -1, 0);
    drain();
    repeat (6) send_block(0, BEATS - 1, 0, -1, 0);
    drain();
    rdy_mode = 2;
    repeat (3) send_block(0, BEATS - 1, 0, -1, 0);
    idle(5);
    rdy_mode = 0;
    drain();
    send_block(0, 20, 0, -1, 0);
    beat(0, 0, 0, DW'($urandom));
    idle(2);
    beat(1, 0, 0, DW'($urandom));
    repeat (4) beat(0, 0, 0, DW'($urandom));
    beat(1, 0, 0, DW'($urandom));
    idle(2);
    send_block(0, BEATS, 0, -1, 0);
    send_block(0, BEATS - 1, 0, -1, 0);
    drain();
    send_block(0, BEATS - 1, 0, -1, 0);
    send_block(1, BEATS - 1, 0, -1, 0);
    drain();
    rdy_mode = 1;
    send_block(0, BEATS - 1, 0, 10, 0);
    idle(3);
    send_block(1, BEATS - 1, 10, -1, 0);
    drain();
    @(posedge clk);
    #1 ending = 1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
